buffer_ram_reader: RTL

//  Frame-scan reader on the read port of the pixel buffer RAM. On START it walks linear

---
 rtl/buffer_ram_reader_pkg.sv | 30 +++
 rtl/buffer_ram_reader_if.sv | 27 ++
 rtl/buffer_ram_reader.sv | 99 +++++++++
 3 files changed

// File: rtl/buffer_ram_reader_pkg.sv
// st7789_pkg: reader FSM states, pixel type, bytes per pixel and RGB byte packers.
// Build option: BUFFER_RAM_READER_RGB666_EN selects 18-bit (3 bytes/pixel) output.
package st7789_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, SEND_HI, SEND_MID, SEND_LO} reader_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

`ifdef BUFFER_RAM_READER_RGB666_EN
    localparam int BYTES_PER_PIXEL = 3;
`else
    localparam int BYTES_PER_PIXEL = 2;
`endif

    // Byte idx of an RGB565 pixel: 0 = {R5,G3 high}, otherwise {G3 low,B5}
    function automatic logic [7:0] pack_rgb565(pixel_t p, logic [1:0] idx);
        return (idx == 2'd0) ? {p.r[7:3], p.g[7:5]} : {p.g[4:2], p.b[7:3]};
    endfunction

    // Byte idx of an RGB666 pixel: 0 = R, 1 = G, otherwise B, each left-aligned
    function automatic logic [7:0] pack_rgb666(pixel_t p, logic [1:0] idx);
        return (idx == 2'd0) ? {p.r[7:2], 2'b00} :
               (idx == 2'd1) ? {p.g[7:2], 2'b00} : {p.b[7:2], 2'b00};
    endfunction

endpackage

// File: rtl/buffer_ram_reader_if.sv
// buffer_ram_reader_if: buffer RAM read port plus valid/ready byte stream to the serializer.
interface buffer_ram_reader_if #(parameter int ADDR_W = 16);

    logic [ADDR_W-1:0] READ_RAM_ADDRESS;
    logic [7:0]        READ_RAM_COLOR_R;
    logic [7:0]        READ_RAM_COLOR_G;
    logic [7:0]        READ_RAM_COLOR_B;
    logic [7:0]        OUT_DATA;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic              OUT_LAST;

    modport master (
        output READ_RAM_ADDRESS,
        input  READ_RAM_COLOR_R, READ_RAM_COLOR_G, READ_RAM_COLOR_B,
        output OUT_DATA, OUT_VALID, OUT_LAST,
        input  OUT_READY
    );

    modport slave (
        input  READ_RAM_ADDRESS,
        output READ_RAM_COLOR_R, READ_RAM_COLOR_G, READ_RAM_COLOR_B,
        input  OUT_DATA, OUT_VALID, OUT_LAST,
        output OUT_READY
    );

endinterface

// File: rtl/buffer_ram_reader.sv
// buffer_ram_reader: scans the pixel buffer RAM once per START and streams ST7789 pixel bytes.
// Build option: BUFFER_RAM_READER_RGB666_EN streams RGB666 (3 bytes/pixel) instead of RGB565.
module buffer_ram_reader
    import st7789_pkg::*;
#(
    parameter int X_LIMIT = 240,
    parameter int Y_LIMIT = 240
) (
    input  logic CLK,
    input  logic RESET,
    input  logic START,
    output logic BUSY,
    output logic FRAME_DONE,
    buffer_ram_reader_if.master bus
);

    localparam int ADDR_W = $clog2(X_LIMIT) + $clog2(Y_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(X_LIMIT * Y_LIMIT - 1);

    reader_state_t     state, next;
    logic [ADDR_W-1:0] addr, pcnt, addr_inc;
    pixel_t            pix, ram_pix;
    logic              hs, last_pix;
    logic [1:0]        idx;

    assign ram_pix  = {bus.READ_RAM_COLOR_R, bus.READ_RAM_COLOR_G, bus.READ_RAM_COLOR_B};
    assign hs       = bus.OUT_VALID && bus.OUT_READY;
    assign last_pix = pcnt == LAST_PIX;
    assign addr_inc = (addr == LAST_PIX) ? addr : addr + 1'b1;
    assign idx      = (state == SEND_HI) ? 2'd0 : (state == SEND_MID) ? 2'd1 : 2'(BYTES_PER_PIXEL - 1);

    assign bus.READ_RAM_ADDRESS = addr;
    assign bus.OUT_VALID        = state inside {SEND_HI, SEND_MID, SEND_LO};
    assign bus.OUT_LAST         = (state == SEND_LO) && last_pix;
`ifdef BUFFER_RAM_READER_RGB666_EN
    assign bus.OUT_DATA         = bus.OUT_VALID ? pack_rgb666(pix, idx) : 8'h00;
`else
    assign bus.OUT_DATA         = bus.OUT_VALID ? pack_rgb565(pix, idx) : 8'h00;
`endif

    // State register; reset aborts any frame in progress
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= next;
    end

    // Next state: one fetch cycle, then one byte state per handshake
    always_comb begin
        next = state;
        case (state)
            IDLE:     next = START ? FETCH : IDLE;
            FETCH:    next = SEND_HI;
`ifdef BUFFER_RAM_READER_RGB666_EN
            SEND_HI:  next = hs ? SEND_MID : SEND_HI;
            SEND_MID: next = hs ? SEND_LO : SEND_MID;
`else
            SEND_HI:  next = hs ? SEND_LO : SEND_HI;
`endif
            SEND_LO:  next = hs ? (last_pix ? IDLE : SEND_HI) : SEND_LO;
            default:  next = IDLE;
        endcase
    end

    // Address, pixel count and pixel capture; address rests at 0 in IDLE so the
    // RAM already presents pixel 0 when FETCH captures it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr       <= '0;
            pcnt       <= '0;
            pix        <= '0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            if (state == IDLE && START) begin
                addr <= '0;
                pcnt <= '0;
                BUSY <= 1'b1;
            end
            if (state == FETCH) begin
                pix  <= ram_pix;
                addr <= addr_inc;
            end
            if (state == SEND_LO && hs) begin
                if (last_pix) begin
                    addr       <= '0;
                    pcnt       <= '0;
                    BUSY       <= 1'b0;
                    FRAME_DONE <= 1'b1;
                end else begin
                    pix  <= ram_pix;
                    addr <= addr_inc;
                    pcnt <= pcnt + 1'b1;
                end
            end
        end
    end

endmodule
